// File: rtl/fetch_stage.sv
// Fetch stage: holds the architectural PC, issues I-cache requests and feeds the DE latch.
// Branch stalls, pending redirects during a miss and a saturating miss-cycle counter are tracked here.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h3000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             icache_req,
  output logic [15:0]      icache_addr,
  input  logic [15:0]      icache_rdata,
  input  logic             icache_ready,
  input  logic             dep_stall,
  input  logic             mem_stall,
  input  logic             v_de_br_stall,
  input  logic             v_agex_br_stall,
  input  logic             v_mem_br_stall,
  input  logic [1:0]       mem_pcmux,
  input  logic [15:0]      target_pc,
  input  logic [15:0]      trap_pc,
  output logic [15:0]      fe_pc,
  output logic [15:0]      de_npc,
  output logic [15:0]      de_ir,
  output logic             de_v,
  output logic [CNT_W-1:0] fe_stall_cnt
);

  typedef enum logic [1:0] {
    FE_RUN    = 2'd0,
    FE_WAIT   = 2'd1,
    FE_BRWAIT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      fe_pc_q, fe_pc_d;
  logic [15:0]      de_npc_q, de_npc_d;
  logic [15:0]      de_ir_q, de_ir_d;
  logic             de_v_q, de_v_d;
  logic             pend_v_q, pend_v_d;
  logic [15:0]      pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             ld_de;
  logic             br_stall;
  logic             redir;
  logic [15:0]      redir_pc;
  logic [15:0]      pc_inc;

  always_comb begin
    ld_de    = ~(dep_stall | mem_stall);
    br_stall = v_de_br_stall | v_agex_br_stall | v_mem_br_stall;
    redir    = ((mem_pcmux == 2'd1) || (mem_pcmux == 2'd2)) && !mem_stall;
    redir_pc = ((mem_pcmux == 2'd2) ? trap_pc : target_pc) & 16'hFFFE;
    pc_inc   = fe_pc_q + 16'd2;
  end

  always_comb begin
    // NOTE: every signal gets a hold default first so no path can infer a latch.
    state_d   = state_q;
    fe_pc_d   = fe_pc_q;
    de_npc_d  = de_npc_q;
    de_ir_d   = de_ir_q;
    de_v_d    = de_v_q;
    pend_v_d  = pend_v_q;
    pend_pc_d = pend_pc_q;
    cnt_d     = cnt_q;

    if (state_q == FE_WAIT && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      FE_BRWAIT: begin
        if (ld_de) de_v_d = 1'b0;
        if (redir) begin
          fe_pc_d = redir_pc;
          state_d = FE_RUN;
        end else if (!br_stall) begin
          fe_pc_d = pc_inc;
          state_d = FE_RUN;
        end
      end

      default: begin
        if (!icache_ready) begin
          // The address must stay put while the miss is outstanding, so a redirect is parked.
          state_d = FE_WAIT;
          if (ld_de) de_v_d = 1'b0;
          if (redir) begin
            pend_v_d  = 1'b1;
            pend_pc_d = redir_pc;
          end
        end else begin
          state_d = FE_RUN;
          if (ld_de) begin
            de_npc_d = pc_inc;
            de_ir_d  = icache_rdata;
            de_v_d   = ~br_stall & ~redir & ~pend_v_q;
          end
          if (redir || pend_v_q) begin
            fe_pc_d  = redir ? redir_pc : pend_pc_q;
            pend_v_d = 1'b0;
          end else if (ld_de) begin
            if (br_stall) state_d = FE_BRWAIT;
            else          fe_pc_d = pc_inc;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FE_RUN;
      fe_pc_q   <= RESET_PC;
      de_npc_q  <= '0;
      de_ir_q   <= '0;
      de_v_q    <= 1'b0;
      pend_v_q  <= 1'b0;
      pend_pc_q <= '0;
      cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      state_q   <= state_d;
      fe_pc_q   <= fe_pc_d;
      de_npc_q  <= de_npc_d;
      de_ir_q   <= de_ir_d;
      de_v_q    <= de_v_d;
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
      cnt_q     <= cnt_d;
    end
  end

  assign icache_req   = (state_q != FE_BRWAIT) | pend_v_q;
  assign icache_addr  = fe_pc_q;
  assign fe_pc        = fe_pc_q;
  assign de_npc       = de_npc_q;
  assign de_ir        = de_ir_q;
  assign de_v         = de_v_q;
  assign fe_stall_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with fixed expectations, then randomized
// traffic compared against a flag-based behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             icache_req;
  logic [15:0]      icache_addr;
  logic [15:0]      icache_rdata;
  logic             icache_ready = 1'b1;
  logic             dep_stall = 1'b0;
  logic             mem_stall = 1'b0;
  logic             v_de_br_stall = 1'b0;
  logic             v_agex_br_stall = 1'b0;
  logic             v_mem_br_stall = 1'b0;
  logic [1:0]       mem_pcmux = 2'd0;
  logic [15:0]      target_pc = 16'h0;
  logic [15:0]      trap_pc = 16'h0;
  logic [15:0]      fe_pc;
  logic [15:0]      de_npc;
  logic [15:0]      de_ir;
  logic             de_v;
  logic [CNT_W-1:0] fe_stall_cnt;

  int checks = 0;
  int failures = 0;

  fetch_stage #(.RESET_PC(16'h3000), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_rdata(icache_rdata), .icache_ready(icache_ready),
    .dep_stall(dep_stall), .mem_stall(mem_stall),
    .v_de_br_stall(v_de_br_stall), .v_agex_br_stall(v_agex_br_stall),
    .v_mem_br_stall(v_mem_br_stall), .mem_pcmux(mem_pcmux),
    .target_pc(target_pc), .trap_pc(trap_pc),
    .fe_pc(fe_pc), .de_npc(de_npc), .de_ir(de_ir), .de_v(de_v),
    .fe_stall_cnt(fe_stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  assign icache_rdata = icache_ready ? memf(icache_addr) : 16'hDEAD;

  // Behavioural model: boolean "missing"/"branch-waiting"/"redirect parked" flags.
  logic [15:0] m_pc, m_npc, m_ir, m_pend_pc;
  logic        m_v;
  int          m_cnt;
  bit          m_miss, m_brw, m_pend;

  always @(posedge clk or negedge rst_n) begin
    bit ld, brs, rd;
    logic [15:0] rpc;
    if (!rst_n) begin
      m_pc = 16'h3000; m_npc = 0; m_ir = 0; m_v = 0; m_cnt = 0;
      m_miss = 0; m_brw = 0; m_pend = 0; m_pend_pc = 0;
    end else begin
      ld  = !(dep_stall || mem_stall);
      brs = v_de_br_stall || v_agex_br_stall || v_mem_br_stall;
      rd  = (mem_pcmux == 2'd1 || mem_pcmux == 2'd2) && !mem_stall;
      rpc = (mem_pcmux == 2'd2) ? {trap_pc[15:1], 1'b0} : {target_pc[15:1], 1'b0};
      if (m_miss && m_cnt < int'(CNT_MAX)) m_cnt++;
      if (m_brw) begin
        if (ld) m_v = 0;
        if (rd) begin m_pc = rpc; m_brw = 0; end
        else if (!brs) begin m_pc = m_pc + 16'd2; m_brw = 0; end
      end else if (!icache_ready) begin
        m_miss = 1;
        if (ld) m_v = 0;
        if (rd) begin m_pend = 1; m_pend_pc = rpc; end
      end else begin
        m_miss = 0;
        if (ld) begin
          m_npc = m_pc + 16'd2;
          m_ir  = memf(m_pc);
          m_v   = !brs && !rd && !m_pend;
        end
        if (rd || m_pend) begin
          m_pc = rd ? rpc : m_pend_pc;
          m_pend = 0;
        end else if (ld) begin
          if (brs) m_brw = 1;
          else m_pc = m_pc + 16'd2;
        end
      end
    end
  end

  task automatic idle_inputs();
    dep_stall = 0; mem_stall = 0;
    v_de_br_stall = 0; v_agex_br_stall = 0; v_mem_br_stall = 0;
    mem_pcmux = 2'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    icache_ready = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    checks++; if (fe_pc !== 16'h3000) begin failures++; $display("FAIL reset_pc got=%h exp=3000", fe_pc); end
    checks++; if (de_v !== 1'b0 || de_npc !== 16'h0 || de_ir !== 16'h0) begin
      failures++; $display("FAIL reset_de got v=%b npc=%h ir=%h exp 0/0000/0000", de_v, de_npc, de_ir);
    end
    checks++; if (fe_stall_cnt !== '0 || icache_req !== 1'b1) begin
      failures++; $display("FAIL reset_cnt_req got cnt=%0d req=%b exp 0/1", fe_stall_cnt, icache_req);
    end
    @(negedge clk);
    icache_ready = 1;
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      logic [15:0] exp_addr;
      exp_addr = 16'h3000 + 16'(2 * i);
      checks++; if (icache_addr !== exp_addr) begin
        failures++; $display("FAIL seq_addr%0d got=%h exp=%h", i, icache_addr, exp_addr);
      end
      checks++; if (de_v !== (i > 0)) begin
        failures++; $display("FAIL seq_v%0d got=%b exp=%b", i, de_v, (i > 0));
      end
      if (i == 1) begin
        checks++; if (de_npc !== 16'h3002 || de_ir !== memf(16'h3000)) begin
          failures++; $display("FAIL seq_de got npc=%h ir=%h exp 3002/%h", de_npc, de_ir, memf(16'h3000));
        end
      end
      if (i < 2) @(negedge clk);
    end
  endtask

  task automatic test_miss();
    icache_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (icache_addr !== 16'h3004 || icache_req !== 1'b1 || de_v !== 1'b0) begin
        failures++; $display("FAIL miss_hold%0d got addr=%h req=%b v=%b exp 3004/1/0", i, icache_addr, icache_req, de_v);
      end
    end
    icache_ready = 1;
    @(negedge clk);
    checks++; if (fe_stall_cnt !== 4'd3) begin failures++; $display("FAIL miss_cnt got=%0d exp=3", fe_stall_cnt); end
    checks++; if (icache_addr !== 16'h3006 || de_v !== 1'b1 || de_npc !== 16'h3006 || de_ir !== memf(16'h3004)) begin
      failures++; $display("FAIL miss_resume got addr=%h v=%b npc=%h ir=%h exp 3006/1/3006/%h",
                           icache_addr, de_v, de_npc, de_ir, memf(16'h3004));
    end
  endtask

  task automatic test_branch();
    v_de_br_stall = 1;
    @(negedge clk);
    checks++; if (icache_req !== 1'b0 || de_v !== 1'b0 || fe_pc !== 16'h3006) begin
      failures++; $display("FAIL br_enter got req=%b v=%b pc=%h exp 0/0/3006", icache_req, de_v, fe_pc);
    end
    v_de_br_stall = 0; v_agex_br_stall = 1;
    @(negedge clk);
    v_agex_br_stall = 0; v_mem_br_stall = 1;
    @(negedge clk);
    checks++; if (icache_req !== 1'b0 || de_v !== 1'b0 || fe_pc !== 16'h3006) begin
      failures++; $display("FAIL br_wait got req=%b v=%b pc=%h exp 0/0/3006", icache_req, de_v, fe_pc);
    end
    mem_pcmux = 2'd1; target_pc = 16'h4001;
    @(negedge clk);
    checks++; if (icache_req !== 1'b1 || icache_addr !== 16'h4000 || de_v !== 1'b0) begin
      failures++; $display("FAIL br_target got req=%b addr=%h v=%b exp 1/4000/0", icache_req, icache_addr, de_v);
    end
    idle_inputs();
    @(negedge clk);
    checks++; if (de_v !== 1'b1 || de_npc !== 16'h4002 || de_ir !== memf(16'h4000)) begin
      failures++; $display("FAIL br_first got v=%b npc=%h ir=%h exp 1/4002/%h", de_v, de_npc, de_ir, memf(16'h4000));
    end
  endtask

  task automatic test_redirect_miss();
    mem_pcmux = 2'd1; target_pc = 16'h3008;
    @(negedge clk);
    mem_pcmux = 2'd0; icache_ready = 0;
    @(negedge clk);
    mem_pcmux = 2'd2; trap_pc = 16'h0200;
    @(negedge clk);
    mem_pcmux = 2'd0;
    checks++; if (icache_addr !== 16'h3008 || icache_req !== 1'b1 || de_v !== 1'b0) begin
      failures++; $display("FAIL rm_hold got addr=%h req=%b v=%b exp 3008/1/0", icache_addr, icache_req, de_v);
    end
    @(negedge clk);
    icache_ready = 1;
    @(negedge clk);
    checks++; if (icache_addr !== 16'h0200 || de_v !== 1'b0) begin
      failures++; $display("FAIL rm_discard got addr=%h v=%b exp 0200/0", icache_addr, de_v);
    end
    @(negedge clk);
    checks++; if (de_v !== 1'b1 || de_npc !== 16'h0202 || de_ir !== memf(16'h0200)) begin
      failures++; $display("FAIL rm_after got v=%b npc=%h ir=%h exp 1/0202/%h", de_v, de_npc, de_ir, memf(16'h0200));
    end
  endtask

  task automatic test_dep_stall();
    dep_stall = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (de_v !== 1'b1 || de_npc !== 16'h0202 || de_ir !== memf(16'h0200) || fe_pc !== 16'h0202) begin
        failures++; $display("FAIL dep_hold%0d got v=%b npc=%h ir=%h pc=%h exp 1/0202/%h/0202",
                             i, de_v, de_npc, de_ir, fe_pc, memf(16'h0200));
      end
    end
    dep_stall = 0;
    @(negedge clk);
    checks++; if (de_v !== 1'b1 || de_npc !== 16'h0204 || de_ir !== memf(16'h0202) || fe_pc !== 16'h0204) begin
      failures++; $display("FAIL dep_accept got v=%b npc=%h ir=%h pc=%h exp 1/0204/%h/0204",
                           de_v, de_npc, de_ir, fe_pc, memf(16'h0202));
    end
  endtask

  task automatic test_wraparound();
    mem_pcmux = 2'd1; target_pc = 16'hFFFF;
    @(negedge clk);
    mem_pcmux = 2'd0;
    checks++; if (icache_addr !== 16'hFFFE) begin failures++; $display("FAIL wrap_target got=%h exp=FFFE", icache_addr); end
    @(negedge clk);
    checks++; if (icache_addr !== 16'h0000 || de_npc !== 16'h0000 || de_v !== 1'b1 || de_ir !== memf(16'hFFFE)) begin
      failures++; $display("FAIL wrap_next got addr=%h npc=%h v=%b ir=%h exp 0000/0000/1/%h",
                           icache_addr, de_npc, de_v, de_ir, memf(16'hFFFE));
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      icache_ready    = ($urandom_range(99) < 70);
      dep_stall       = ($urandom_range(99) < 15);
      mem_stall       = ($urandom_range(99) < 10);
      v_de_br_stall   = ($urandom_range(99) < 10);
      v_agex_br_stall = ($urandom_range(99) < 8);
      v_mem_br_stall  = ($urandom_range(99) < 8);
      mem_pcmux       = ($urandom_range(99) < 15) ? 2'($urandom_range(3)) : 2'd0;
      target_pc       = 16'($urandom);
      trap_pc         = 16'($urandom);
      @(negedge clk);
      checks++; if (icache_addr !== m_pc || fe_pc !== m_pc) begin
        failures++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", cyc, icache_addr, m_pc);
      end
      checks++; if (icache_req !== (!m_brw || m_pend)) begin
        failures++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, icache_req, (!m_brw || m_pend));
      end
      checks++; if (de_v !== m_v) begin
        failures++; $display("FAIL rnd_v cyc=%0d got=%b exp=%b", cyc, de_v, m_v);
      end
      if (m_v) begin
        checks++; if (de_npc !== m_npc || de_ir !== m_ir) begin
          failures++; $display("FAIL rnd_de cyc=%0d got npc=%h ir=%h exp %h/%h", cyc, de_npc, de_ir, m_npc, m_ir);
        end
      end
      checks++; if (int'(fe_stall_cnt) != m_cnt) begin
        failures++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", cyc, fe_stall_cnt, m_cnt);
      end
    end
    idle_inputs();
    icache_ready = 1;
  endtask

  initial begin
    test_reset();
    test_miss();
    test_branch();
    test_redirect_miss();
    test_dep_stall();
    test_wraparound();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
